instr_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the RISCuin instruction decoder. It replaces the combinational `memory[pc]` lookup with a request/acknowledge fetch from a variable-latency program memory. Fetched words are buffered in a small FIFO and delivered to the core with a valid/ready handshake. Branches and jumps are handled through a redirect input that flushes the buffer and discards any in-flight response.

---
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit : req/ack program-memory fetch with an {instr, pc} FIFO and a redirect flush
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter int                          INSTR_ADDR_WIDTH = 8,
    parameter int                          DEPTH            = 4,
    parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_PC         = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        mem_req,
    output logic [INSTR_ADDR_WIDTH-1:0] mem_addr,
    input  logic                        mem_ack,
    input  logic [31:0]                 mem_rdata,
    output logic [31:0]                 instr,
    output logic [INSTR_ADDR_WIDTH-1:0] instr_pc,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    input  logic                        redirect,
    input  logic [INSTR_ADDR_WIDTH-1:0] redirect_pc,
    output logic                        fetch_done
);

    localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    typedef enum logic [0:0] {
        ST_FETCH   = 1'b0,
        ST_DISCARD = 1'b1
    } state_e;

    state_e                      state_q, state_d;
    logic [INSTR_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [INSTR_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                        pending_q, pending_d;
    logic                        active_q;
    logic                        fetch_done_q, fetch_done_d;
    logic [CW-1:0]               count_q, count_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;

    logic [31:0]                 word_mem [DEPTH];
    logic [INSTR_ADDR_WIDTH-1:0] pc_mem   [DEPTH];

    logic                        req;
    logic [INSTR_ADDR_WIDTH-1:0] cur_addr;
    logic                        xfer;
    logic                        push;
    logic                        pop;
    logic                        not_empty;

    // While a request is outstanding the held address is presented; otherwise the next pc.
    assign cur_addr  = pending_q ? mem_addr_q : pc_q;
    assign req       = pending_q
                     | (active_q && (state_q == ST_FETCH) && !fetch_done_q && (count_q < DEPTH_C));
    assign xfer      = req && mem_ack;
    assign not_empty = (count_q != '0);
    assign pop       = not_empty && instr_ready;
    assign push      = xfer && (state_q == ST_FETCH) && !redirect;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_done_d = fetch_done_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        pending_d    = req && !mem_ack;
        mem_addr_d   = req ? cur_addr : mem_addr_q;

        if (redirect) begin
            // An unacked request must still be drained, so its response is discarded later.
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            pc_d         = redirect_pc;
            fetch_done_d = 1'b0;
            state_d      = (req && !mem_ack) ? ST_DISCARD : ST_FETCH;
        end else begin
            if (xfer) begin
                if (state_q == ST_DISCARD) begin
                    state_d = ST_FETCH;
                end else if (cur_addr == '1) begin
                    fetch_done_d = 1'b1;
                end else begin
                    pc_d = cur_addr + INSTR_ADDR_WIDTH'(1);
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            mem_addr_q   <= RESET_PC;
            pending_q    <= 1'b0;
            active_q     <= 1'b0;
            fetch_done_q <= 1'b0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_addr_q   <= mem_addr_d;
            pending_q    <= pending_d;
            active_q     <= 1'b1;
            fetch_done_q <= fetch_done_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    // Payload storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr_q] <= mem_rdata;
            pc_mem[wr_ptr_q]   <= cur_addr;
        end
    end

    assign mem_req     = req;
    assign mem_addr    = cur_addr;
    assign instr_valid = not_empty;
    assign instr       = not_empty ? word_mem[rd_ptr_q] : '0;
    assign instr_pc    = not_empty ? pc_mem[rd_ptr_q]   : '0;
    assign fetch_done  = fetch_done_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit : directed self-checking bench for instr_fetch_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        fetch_done;

    int          checks;
    int          failures;
    int          hs_cnt;
    int          hs_base;
    int          wait_cnt;
    logic        ack_slow;

    instr_fetch_unit #(
        .INSTR_ADDR_WIDTH (8),
        .DEPTH            (4),
        .RESET_PC         (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_done  (fetch_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: word at address a is 0xC0DE0000 + a.
    assign mem_rdata = 32'hC0DE_0000 | {24'h0, mem_addr};
    // Fast mode acks every cycle; slow mode acks 3 cycles after mem_req rises.
    assign mem_ack   = ack_slow ? (mem_req && (wait_cnt == 3)) : 1'b1;

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
        if (mem_req && mem_ack)  hs_cnt <= hs_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        hs_cnt      = 0;
        wait_cnt    = 0;
        ack_slow    = 1'b0;
        rst         = 1'b0;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 8'h00;

        // Reset state
        tick();
        tick();
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", {24'b0, instr_pc}, 32'd0);
        chk("rst_fetch_done", {31'b0, fetch_done}, 32'd0);
        chk("rst_mem_addr", {24'b0, mem_addr}, 32'd0);

        // Zero-wait streaming
        rst = 1'b1;
        tick();
        chk("first_req", {31'b0, mem_req}, 32'd1);
        chk("first_addr", {24'b0, mem_addr}, 32'd0);
        chk("first_valid", {31'b0, instr_valid}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("stream_addr", {24'b0, mem_addr}, 32'(k + 1));
            chk("stream_pc", {24'b0, instr_pc}, 32'(k));
            chk("stream_instr", instr, 32'hC0DE_0000 + 32'(k));
        end

        // Backpressure fills the FIFO with exactly four words
        instr_ready = 1'b0;
        do_reset();
        hs_base = hs_cnt;
        for (int k = 0; k < 5; k++) tick();
        chk("full_req", {31'b0, mem_req}, 32'd0);
        chk("full_pc", {24'b0, instr_pc}, 32'd0);
        chk("full_hs", 32'(hs_cnt - hs_base), 32'd4);
        tick();
        tick();
        chk("full_req_hold", {31'b0, mem_req}, 32'd0);
        chk("full_pc_hold", {24'b0, instr_pc}, 32'd0);
        chk("full_hs_hold", 32'(hs_cnt - hs_base), 32'd4);
        instr_ready = 1'b1;
        tick();
        chk("drain_pc1", {24'b0, instr_pc}, 32'd1);
        chk("resume_addr", {24'b0, mem_addr}, 32'd4);
        chk("resume_req", {31'b0, mem_req}, 32'd1);
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk("drain_pc", {24'b0, instr_pc}, 32'(k));
            chk("drain_instr", instr, 32'hC0DE_0000 + 32'(k));
        end

        // Ack latency 3: one word per four cycles
        ack_slow = 1'b1;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k != 0) begin
                chk("slow_valid", {31'b0, instr_valid}, 32'd1);
                chk("slow_pc", {24'b0, instr_pc}, 32'(k - 1));
            end
            chk("slow_req", {31'b0, mem_req}, 32'd1);
            chk("slow_addr_a", {24'b0, mem_addr}, 32'(k));
            tick();
            chk("slow_gap", {31'b0, instr_valid}, 32'd0);
            chk("slow_addr_b", {24'b0, mem_addr}, 32'(k));
            chk("slow_noack", {31'b0, mem_ack}, 32'd0);
            tick();
            chk("slow_addr_c", {24'b0, mem_addr}, 32'(k));
            tick();
            chk("slow_addr_d", {24'b0, mem_addr}, 32'(k));
            chk("slow_ack", {31'b0, mem_ack}, 32'd1);
        end

        // Redirect while 0x05 is pending
        tick();
        chk("pre_redir_pc", {24'b0, instr_pc}, 32'd4);
        chk("pre_redir_addr", {24'b0, mem_addr}, 32'h05);
        tick();
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        tick();
        redirect = 1'b0;
        chk("disc_req", {31'b0, mem_req}, 32'd1);
        chk("disc_addr", {24'b0, mem_addr}, 32'h05);
        chk("disc_valid", {31'b0, instr_valid}, 32'd0);
        tick();
        chk("disc_addr2", {24'b0, mem_addr}, 32'h05);
        chk("disc_ack", {31'b0, mem_ack}, 32'd1);
        tick();
        chk("redir_addr", {24'b0, mem_addr}, 32'h40);
        chk("redir_req", {31'b0, mem_req}, 32'd1);
        chk("dropped_valid", {31'b0, instr_valid}, 32'd0);
        tick();
        tick();
        tick();
        chk("redir_wait_valid", {31'b0, instr_valid}, 32'd0);
        chk("redir_wait_ack", {31'b0, mem_ack}, 32'd1);
        tick();
        chk("redir_first_valid", {31'b0, instr_valid}, 32'd1);
        chk("redir_first_pc", {24'b0, instr_pc}, 32'h40);
        chk("redir_first_instr", instr, 32'hC0DE_0040);

        // Redirect on the same edge as an ack: word 0x41 must be dropped
        ack_slow    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 8'h20;
        tick();
        redirect = 1'b0;
        chk("same_edge_valid", {31'b0, instr_valid}, 32'd0);
        chk("same_edge_addr", {24'b0, mem_addr}, 32'h20);
        tick();
        chk("same_edge_pc", {24'b0, instr_pc}, 32'h20);

        // Top of address space stops fetching
        redirect    = 1'b1;
        redirect_pc = 8'hFE;
        tick();
        redirect = 1'b0;
        chk("top_addr", {24'b0, mem_addr}, 32'hFE);
        tick();
        chk("top_pc_fe", {24'b0, instr_pc}, 32'hFE);
        chk("top_done_early", {31'b0, fetch_done}, 32'd0);
        tick();
        chk("top_pc_ff", {24'b0, instr_pc}, 32'hFF);
        chk("top_instr_ff", instr, 32'hC0DE_00FF);
        chk("top_done", {31'b0, fetch_done}, 32'd1);
        chk("top_noreq", {31'b0, mem_req}, 32'd0);
        tick();
        tick();
        chk("top_empty", {31'b0, instr_valid}, 32'd0);
        chk("top_noreq2", {31'b0, mem_req}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = 8'h10;
        tick();
        redirect = 1'b0;
        chk("restart_done", {31'b0, fetch_done}, 32'd0);
        chk("restart_req", {31'b0, mem_req}, 32'd1);
        chk("restart_addr", {24'b0, mem_addr}, 32'h10);
        tick();
        chk("restart_pc", {24'b0, instr_pc}, 32'h10);

        // Asynchronous reset while a request is pending and two words are buffered
        ack_slow    = 1'b1;
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("mid_valid", {31'b0, instr_valid}, 32'd1);
        chk("mid_pc", {24'b0, instr_pc}, 32'h10);
        chk("mid_req", {31'b0, mem_req}, 32'd1);
        chk("mid_addr", {24'b0, mem_addr}, 32'h12);
        #2;
        rst = 1'b0;
        #1;
        chk("async_req", {31'b0, mem_req}, 32'd0);
        chk("async_valid", {31'b0, instr_valid}, 32'd0);
        chk("async_instr", instr, 32'd0);
        chk("async_pc", {24'b0, instr_pc}, 32'd0);
        chk("async_addr", {24'b0, mem_addr}, 32'd0);
        tick();
        ack_slow    = 1'b0;
        instr_ready = 1'b1;
        rst         = 1'b1;
        tick();
        chk("rerun_req", {31'b0, mem_req}, 32'd1);
        chk("rerun_addr", {24'b0, mem_addr}, 32'd0);
        tick();
        chk("rerun_pc", {24'b0, instr_pc}, 32'd0);
        chk("rerun_instr", instr, 32'hC0DE_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
